// File: rtl/snake_pixel_gen_if.sv
// Purpose: bus between the snake pixel generator and its tile RAM, game logic and display stage.
// Latency: n/a (wiring only); tile_data is expected one cycle after tile_addr.
// Backpressure: none, every signal is sampled every pixel clock.
// Ports: tile_data (RAM read data), game_over (level), tile_addr (RAM address),
//        rgb (registered pixel colour), frame_tick (start-of-vblank pulse).
// master = pixel generator, slave = environment (tile RAM, game logic, display).
interface snake_pixel_gen_if;
    logic [1:0]  tile_data;
    logic        game_over;
    logic [10:0] tile_addr;
    logic [11:0] rgb;
    logic        frame_tick;

    modport master (
        input  tile_data,
        input  game_over,
        output tile_addr,
        output rgb,
        output frame_tick
    );

    modport slave (
        output tile_data,
        output game_over,
        input  tile_addr,
        input  rgb,
        input  frame_tick
    );
endinterface

// File: rtl/snake_pixel_gen.sv
// Purpose: raster-locked pixel colour generator for a 40x30 grid of 16x16 snake tiles.
// Latency: 2 cycles from fetch position to rgb (RAM read stage, colour stage).
// Backpressure: none, advances one pixel every clk25 cycle while rst is low.
// Ports: clk25 (pixel clock), rst (sync, active high), pix (snake_pixel_gen_if.master:
//        tile_data/game_over in, tile_addr/rgb/frame_tick out).
// Geometry parameters default to 800x525 total / 640x480 active.
module snake_pixel_gen #(
    parameter logic [11:0] COL_BG     = 12'h000,
    parameter logic [11:0] COL_BODY   = 12'h0F0,
    parameter logic [11:0] COL_HEAD   = 12'h0A0,
    parameter logic [11:0] COL_FOOD   = 12'hF00,
    parameter logic [11:0] COL_BORDER = 12'h888,
    parameter logic [11:0] COL_GRID   = 12'h222,
    parameter logic [11:0] COL_DEAD   = 12'hFF0,
    parameter bit          GRID_EN    = 1'b0,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_TOTAL    = 800,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_TOTAL    = 525
) (
    input  logic              clk25,
    input  logic              rst,
    snake_pixel_gen_if.master pix
);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [5:0] TX_LAST = 6'(H_ACTIVE / 16 - 1);
    localparam logic [4:0] TY_LAST = 5'(V_ACTIVE / 16 - 1);

    // Fetch position and per-frame state
    logic [9:0]  fx;
    logic [9:0]  fy;
    logic [3:0]  frameCnt;
    logic        deadLatch;

    // Stage 1: travels alongside the tile RAM read
    logic        s1Vld;
    logic        s1Active;
    logic        s1Border;
    logic [3:0]  s1Px;
    logic [3:0]  s1Py;

    // Stage 2: registered colour
    logic [11:0] rgbQ;
    logic [11:0] rgbNext;

    logic [5:0]  tx;
    logic [4:0]  ty;
    logic        active;
    logic        border;
    logic        lineEnd;
    logic        frameEnd;
    logic        blinkOn;

    always_comb begin
        tx       = fx[9:4];
        ty       = fy[8:4];
        active   = (fx < H_ACT) && (fy < V_ACT);
        border   = (tx == 6'd0) || (tx == TX_LAST) || (ty == 5'd0) || (ty == TY_LAST);
        lineEnd  = (fx == H_LAST);
        frameEnd = lineEnd && (fy == V_LAST);
    end

    // ty*40 + tx as two shifts and adds; blanking addresses are parked at 0.
    assign pix.tile_addr  = active ? ({1'b0, ty, 5'b0} + {3'b0, ty, 3'b0} + {5'b0, tx}) : 11'd0;
    assign pix.frame_tick = (fx == 10'd0) && (fy == V_ACT);

    always_ff @(posedge clk25) begin
        if (rst) begin
            fx        <= '0;
            fy        <= '0;
            frameCnt  <= '0;
            deadLatch <= 1'b0;
        end else begin
            if (lineEnd) begin
                fx <= '0;
                fy <= (fy == V_LAST) ? 10'd0 : fy + 10'd1;
            end else begin
                fx <= fx + 10'd1;
            end
            // game_over is sampled only at the frame boundary so a frame is never split.
            if (frameEnd) begin
                frameCnt  <= frameCnt + 4'd1;
                deadLatch <= pix.game_over;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            s1Vld    <= 1'b0;
            s1Active <= 1'b0;
            s1Border <= 1'b0;
            s1Px     <= '0;
            s1Py     <= '0;
        end else begin
            s1Vld    <= 1'b1;
            s1Active <= active;
            s1Border <= border;
            s1Px     <= fx[3:0];
            s1Py     <= fy[3:0];
        end
    end

    // Blink alternates every 8 frames. The last pixels of a frame finish stage 2 after
    // frameCnt moves on, but those are always blanking pixels so the frame stays uniform.
    assign blinkOn = deadLatch & ~frameCnt[3];

    always_comb begin
        rgbNext = 12'h000;
        if (s1Vld && s1Active) begin
            if (s1Border) begin
                rgbNext = COL_BORDER;
            end else begin
                case (pix.tile_data)
                    2'd1:    rgbNext = blinkOn ? COL_DEAD : COL_BODY;
                    2'd2:    rgbNext = blinkOn ? COL_DEAD : COL_HEAD;
                    2'd3:    rgbNext = COL_FOOD;
                    default: rgbNext = (GRID_EN && ((s1Px == 4'd0) || (s1Py == 4'd0))) ? COL_GRID : COL_BG;
                endcase
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            rgbQ <= '0;
        end else begin
            rgbQ <= rgbNext;
        end
    end

    assign pix.rgb = rgbQ;
endmodule
